// File: rtl/clk_rst_seq.sv
// Lock-qualified reset sequencer with phase-accumulator clock-enable strobes.
// Runs entirely in the PLL output clock domain.
module clk_rst_seq #(
  parameter int unsigned               LOCK_FILT = 16,
  parameter int unsigned               RST_HOLD  = 32,
  parameter int unsigned               NUM_CE    = 2,
  parameter int unsigned               ACC_W     = 16,
  parameter logic [NUM_CE*ACC_W-1:0]   CE_INC    = {16'h1000, 16'h8000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              ce_run,
  input  logic              lock_lost_clr,
  output logic              sys_rst,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              lock_lost,
  output logic [1:0]        state,
  output logic [NUM_CE-1:0] ce
);

  localparam int unsigned CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_meta_q, lock_meta_d;
  logic               lock_s_q, lock_s_d;
  logic               sys_rst_q, sys_rst_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [ACC_W-1:0]   acc_q [NUM_CE];
  logic [ACC_W-1:0]   acc_d [NUM_CE];
  logic [ACC_W:0]     sum   [NUM_CE];
  logic [NUM_CE-1:0]  ce_q, ce_d;
  logic               stay_run;
  logic               ce_adv;

  // Saturating increment of the shared filter/hold counter
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(CNT_MAX)) return c;
    return c + CNT_W'(1);
  endfunction

  // Lock synchroniser, sequencing FSM and reset outputs
  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      ST_WAIT: begin
        if (lock_s_q) begin
          state_d = ST_FILTER;
          cnt_d   = '0;
        end
      end
      ST_FILTER: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(LOCK_FILT - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc(cnt_q);
        end
      end
      ST_HOLD: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc(cnt_q);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // A set on the same edge as a clear takes priority
    if (lock_lost_clr) lock_lost_d = 1'b0;
    if ((state_q == ST_RUN) && !lock_s_q) lock_lost_d = 1'b1;

    sys_rst_d   = (state_d != ST_RUN);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  // Accumulators advance only on cycles that stay in RUN, so ce never meets sys_rst
  always_comb begin
    stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
    ce_adv   = stay_run && ce_run;
    ce_d     = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, CE_INC[i*ACC_W +: ACC_W]};
      acc_d[i] = '0;
      if (ce_adv) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        ce_d[i]  = sum[i][ACC_W];
      end else if (stay_run) begin
        acc_d[i] = acc_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      sys_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      ce_q        <= '0;
      for (int i = 0; i < NUM_CE; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      sys_rst_q   <= sys_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      ce_q        <= ce_d;
      for (int i = 0; i < NUM_CE; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign state     = state_q;
  assign sys_rst   = sys_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign ce        = ce_q;

endmodule
